// File: rtl/morse_pkg.sv
// Shared Morse definitions: A-H letter codes, the letter-to-symbol table and
// the receive-side state encoding.
package morse_pkg;

    localparam logic [2:0] WA = 3'd0;
    localparam logic [2:0] WB = 3'd1;
    localparam logic [2:0] WC = 3'd2;
    localparam logic [2:0] WD = 3'd3;
    localparam logic [2:0] WE = 3'd4;
    localparam logic [2:0] WF = 3'd5;
    localparam logic [2:0] WG = 3'd6;
    localparam logic [2:0] WH = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        STUCK = 2'd3
    } morse_state_e;

    // len = symbol count, bits = MSB-first left-justified pattern, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] bits;
    } morse_code_t;

    function automatic morse_code_t letter_code(input logic [2:0] ltr);
        morse_code_t c;
        case (ltr)
            WA:      c = {3'd2, 4'b0100};
            WB:      c = {3'd4, 4'b1000};
            WC:      c = {3'd4, 4'b1010};
            WD:      c = {3'd3, 4'b1000};
            WE:      c = {3'd1, 4'b0000};
            WF:      c = {3'd4, 4'b0010};
            WG:      c = {3'd3, 4'b1100};
            WH:      c = {3'd4, 4'b0000};
            default: c = {3'd0, 4'b0000};
        endcase
        return c;
    endfunction

    // Returns {hit, letter}; hit is 0 when the pattern is not an A-H code.
    function automatic logic [3:0] match_code(input logic [2:0] count,
                                              input logic [3:0] bits);
        logic [3:0]  res;
        morse_code_t c;
        res = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            c = letter_code(3'(i));
            if ((c.len == count) && (c.bits == bits)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Serial line in, decoded letter and symbol progress out.
interface morse_decoder_if;

    logic       morse_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       error;
    logic [3:0] sym_bits;
    logic [2:0] sym_count;

    modport master (
        input  morse_in,
        output letter,
        output letter_valid,
        output error,
        output sym_bits,
        output sym_count
    );

    modport slave (
        output morse_in,
        input  letter,
        input  letter_valid,
        input  error,
        input  sym_bits,
        input  sym_count
    );

endinterface

// File: rtl/morse_sync.sv
// Generic two-flop synchronizer for signals asynchronous to clk.
module morse_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/morse_decoder.sv
// Run-length Morse receiver: classifies marks as dot/dash, detects the
// inter-letter gap and reports the A-H letter code or an error.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic            CLOCK_50,
    input  logic            ResetN,
    morse_decoder_if.master dec
);

    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(TICK_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(2 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(5 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(2 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic             s_s;
    logic             s_d_r;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] run_r;
    logic [3:0]       lookup_s;
    morse_state_e     state_r;
    logic [2:0]       letter_r;
    logic             letter_valid_r;
    logic             error_r;
    logic [3:0]       sym_bits_r;
    logic [2:0]       sym_count_r;
    logic             overflow_r;

    morse_sync #(.WIDTH(1)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (ResetN),
        .d     (dec.morse_in),
        .q     (s_s)
    );

    assign rise_s   = s_s & ~s_d_r;
    assign fall_s   = ~s_s & s_d_r;
    assign lookup_s = match_code(sym_count_r, sym_bits_r);

    // Edge history and run counter; loading 1 on an edge makes run_r equal
    // the full length of the run that just ended when the next edge arrives.
    always_ff @(posedge CLOCK_50 or negedge ResetN) begin
        if (!ResetN) begin
            s_d_r <= 1'b0;
            run_r <= {CNT_W{1'b0}};
        end else begin
            s_d_r <= s_s;
            if (rise_s || fall_s) begin
                run_r <= ONE_C;
            end else if (run_r < STUCK_C) begin
                run_r <= run_r + ONE_C;
            end
        end
    end

    // Decoder FSM with symbol collection, letter resolution and pulses
    always_ff @(posedge CLOCK_50 or negedge ResetN) begin
        if (!ResetN) begin
            state_r        <= IDLE;
            letter_r       <= 3'd0;
            letter_valid_r <= 1'b0;
            error_r        <= 1'b0;
            sym_bits_r     <= 4'b0000;
            sym_count_r    <= 3'd0;
            overflow_r     <= 1'b0;
        end else begin
            letter_valid_r <= 1'b0;
            error_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= rise_s ? MARK : IDLE;
                end
                MARK: begin
                    if (run_r >= STUCK_C) begin
                        error_r     <= 1'b1;
                        sym_bits_r  <= 4'b0000;
                        sym_count_r <= 3'd0;
                        overflow_r  <= 1'b0;
                        state_r     <= STUCK;
                    end else if (fall_s) begin
                        if (run_r < GLITCH_C) begin
                            state_r <= (sym_count_r == 3'd0) ? IDLE : SPACE;
                        end else begin
                            if (sym_count_r < 3'd4) begin
                                sym_bits_r[2'd3 - sym_count_r[1:0]] <= (run_r >= DASH_C);
                                sym_count_r <= sym_count_r + 3'd1;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                            state_r <= SPACE;
                        end
                    end else begin
                        state_r <= MARK;
                    end
                end
                SPACE: begin
                    // A rise in the same cycle the gap completes starts the next letter
                    if (run_r >= GAP_C) begin
                        if (lookup_s[3] && !overflow_r) begin
                            letter_r       <= lookup_s[2:0];
                            letter_valid_r <= 1'b1;
                        end else begin
                            error_r <= 1'b1;
                        end
                        sym_bits_r  <= 4'b0000;
                        sym_count_r <= 3'd0;
                        overflow_r  <= 1'b0;
                        state_r     <= rise_s ? MARK : IDLE;
                    end else begin
                        state_r <= rise_s ? MARK : SPACE;
                    end
                end
                STUCK: begin
                    state_r <= s_s ? STUCK : IDLE;
                end
                default: begin
                    sym_bits_r  <= 4'b0000;
                    sym_count_r <= 3'd0;
                    overflow_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign dec.letter       = letter_r;
    assign dec.letter_valid = letter_valid_r;
    assign dec.error        = error_r;
    assign dec.sym_bits     = sym_bits_r;
    assign dec.sym_count    = sym_count_r;

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side stage for the Morse letter encoder (the SW/KEY-driven A–H transmitter whose output drives LEDR[0]). It samples the encoder's serial on/off line, measures mark and space durations in clock cycles, classifies each mark as dot or dash, and detects the inter-letter gap. At the gap it reports the decoded letter using the same 3-bit A–H code the encoder takes on SW[2:0], or flags an error. Run-length timing makes it tolerant of phase offset between the encoder's 0.5 s tick and this block.

## Interface
- TICK_CYCLES, 25_000_000 — cycles per encoder time unit (0.5 s at 50 MHz); benches use 10
- CNT_W, 28 — run-counter width; must hold 5*TICK_CYCLES
- CLOCK_50  in  1  system clock
- ResetN  in  1  asynchronous, active-low reset
- morse_in  in  1  serial Morse line, 1 = mark (LED on); asynchronous to CLOCK_50
- letter  out  3  decoded letter, A=000 … H=111; holds until the next decode
- letter_valid  out  1  one-cycle pulse, letter updated
- error  out  1  one-cycle pulse, letter rejected
- sym_bits  out  4  symbols collected so far, MSB-first, 1 = dash, left-justified
- sym_count  out  3  number of symbols collected, 0–4

## Operation
- morse_in passes through a 2-flop synchronizer; all logic uses the synchronized value s.
- Thresholds: GLITCH = TICK/2; DASH = 2*TICK; STUCK = 5*TICK; GAP = 2*TICK.
- One run counter, saturating at STUCK; cleared on every edge of s.
- States:
  - IDLE: s low, no symbols held. On s rise, go to MARK.
  - MARK: count the high run.
    - If the count reaches STUCK, pulse error, clear the symbols, and go to STUCK.
    - On s fall with run < GLITCH, discard the mark: return to IDLE if sym_count = 0, else to SPACE with the counter restarted.
    - On s fall with run < DASH, append a dot (0). Otherwise append a dash (1). Then go to SPACE.
  - SPACE: count the low run.
    - On s rise, go to MARK.
    - When the count reaches GAP, resolve the letter and go to IDLE.
  - STUCK: wait for s low, then go to IDLE.
- Append: sym_bits[3 - sym_count] <= symbol; sym_count++.
  - A 5th append sets an internal overflow flag; sym_count stays 4.
- Resolve: match (sym_count, sym_bits) against the table below.
  - On a match with no overflow: latch letter and pulse letter_valid.
  - Otherwise: pulse error; letter keeps its previous value.
  - In both cases clear sym_bits, sym_count and overflow.
- Letter table (length, bits): A 2,0100; B 4,1000; C 4,1010; D 3,1000; E 1,0000; F 4,0010; G 3,1100; H 4,0000.
- letter_valid and error are never asserted in the same cycle.

## Timing
- Reset: state IDLE, synchronizer flops 0, counter 0, letter 000, letter_valid 0, error 0, sym_bits 0000, sym_count 0, overflow 0.
- Reset mid-letter aborts immediately; no pulse is emitted.
- Input latency: 2 cycles through the synchronizer.
- Symbol append is registered; it is visible on sym_bits/sym_count 1 cycle after the falling edge of s is detected.
- letter_valid/error assert in the cycle after the SPACE counter reaches GAP, i.e. GAP+3 cycles after morse_in falls (±1 for sync). sym_bits/sym_count clear in that same cycle.
- Boundaries:
  - A mark exactly GLITCH long counts as a dot.
  - A mark exactly DASH long counts as a dash.
  - A space of exactly GAP-1 cycles followed by a rise continues the letter.
  - A space of exactly GAP resolves the letter.
- The encoder's 1-tick inter-symbol spaces never reach GAP. Its 3-tick dashes are below STUCK.

## Structure
- Shared package morse_pkg holds:
  - letter code constants (the WA–WH values)
  - the letter-to-(length, pattern) table as a function, reused by the encoder
  - the state enum (IDLE, MARK, SPACE, STUCK)
- Sub-module morse_sync: generic 2-flop synchronizer with async active-low reset.
- Run counter, FSM and resolve logic stay in morse_decoder.

## Test plan
Benches use TICK_CYCLES = 10.
- Dot = 10 cycles high, dash = 30 cycles high, 10-cycle low between symbols, then 40 cycles low.
- Send A (dot, dash) → sym_bits 0100 / sym_count 2 before the gap; letter 000 and a letter_valid pulse ~23 cycles after the last fall; counts cleared.
- Send each of B–H back to back, separated by 40-cycle gaps → letter 001…111 in order, 7 letter_valid pulses, no error.
- Send "--" (dash, dash, pattern M) → error pulse; letter unchanged; no letter_valid.
- Send 5 dots → error at the gap, not H. Then insert a 3-cycle high glitch inside the space of a dot-dash letter → glitch ignored, letter A decoded.
- Hold morse_in high for 60 cycles → error when the count reaches 50; no further activity until low. A following E (single dot) decodes to 100.
- Assert ResetN low mid-dash of C → all outputs return to reset values with no pulse. After release, a fresh D decodes correctly.
